// File: rtl/alu_op_sequencer_if.sv
// Board I/O and shifter/ALU datapath signals of the operand sequencer.
// master = sequencer side, slave = board/datapath side.
interface alu_op_sequencer_if;
   logic [31:0] sw;
   logic        btn_load;
   logic        btn_arm;
   logic        btn_show;
   logic [31:0] alu_f;
   logic [3:0]  alu_nzcv;
   logic [31:0] shift_out;
   logic        shift_cout;
   logic [31:0] op_a;
   logic [31:0] shift_data;
   logic [7:0]  shift_num;
   logic [2:0]  shift_op;
   logic [3:0]  alu_op;
   logic        cf;
   logic        vf;
   logic [32:0] disp_data;
   logic [3:0]  res_nzcv;
   logic        res_cout;
   logic [1:0]  step;
   logic        busy;

   modport master (
      input  sw, btn_load, btn_arm, btn_show, alu_f, alu_nzcv, shift_out, shift_cout,
      output op_a, shift_data, shift_num, shift_op, alu_op, cf, vf,
      output disp_data, res_nzcv, res_cout, step, busy
   );

   modport slave (
      output sw, btn_load, btn_arm, btn_show, alu_f, alu_nzcv, shift_out, shift_cout,
      input  op_a, shift_data, shift_num, shift_op, alu_op, cf, vf,
      input  disp_data, res_nzcv, res_cout, step, busy
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Debounced button FSM loading A / shift-data / control from switches, then capturing shifter+ALU results.
// Press-to-output 2+DEBOUNCE_CYCLES+1 cycles, commit-to-capture SETTLE_CYCLES+1; no backpressure. FLAG_WRITEBACK_EN: capture updates cf/vf.
module alu_op_sequencer #(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int SETTLE_CYCLES   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_op_sequencer_if.master  bus
);

   localparam int              DCW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DCW-1:0]  DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]      SETTLE_INI = 4'(SETTLE_CYCLES);
   localparam logic [32:0]     BLANK      = {32'h8888_8888, 1'b0};

   typedef enum logic [2:0] {
      LD_A   = 3'd0,
      LD_SD  = 3'd1,
      LD_CTL = 3'd2,
      SETTLE = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Button order: [0]=load, [1]=arm, [2]=show
   logic [2:0] btn_raw;
   logic [2:0] deb;
   assign btn_raw = {bus.btn_show, bus.btn_arm, bus.btn_load};

   for (genvar g = 0; g < 3; g++) begin : g_deb
      logic           sync1_q;
      logic           sync2_q;
      logic           deb_q;
      logic [DCW-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
         end else begin
            sync1_q <= btn_raw[g];
            sync2_q <= sync1_q;
            if (sync2_q == deb_q) begin
               cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
               deb_q <= sync2_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end

      assign deb[g] = deb_q;
   end

   logic [1:0] deb_prev_q;
   logic       press_load;
   logic       press_show;
   logic       load_ev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_prev_q <= 2'b00;
      end else begin
         deb_prev_q <= {deb[2], deb[0]};
      end
   end

   assign press_load = deb[0] & ~deb_prev_q[0];
   assign press_show = deb[2] & ~deb_prev_q[1];
   assign load_ev    = press_load & deb[1];

   state_t      state_q;
   logic [31:0] op_a_q;
   logic [31:0] shift_data_q;
   logic [7:0]  shift_num_q;
   logic [2:0]  shift_op_q;
   logic [3:0]  alu_op_q;
   logic        cf_q;
   logic        vf_q;
   logic [32:0] disp_q;
   logic [3:0]  res_nzcv_q;
   logic        res_cout_q;
   logic [31:0] res_f_q;
   logic [31:0] res_s_q;
   logic [1:0]  step_q;
   logic        busy_q;
   logic [3:0]  settle_q;
   logic [1:0]  view_q;
   logic [1:0]  view_d;
   logic [32:0] view_disp_d;

   always_comb begin
      view_d = (view_q == 2'd2) ? 2'd0 : view_q + 2'd1;
      case (view_d)
         2'd0:    view_disp_d = {res_f_q, 1'b1};
         2'd1:    view_disp_d = {res_s_q, 1'b1};
         default: view_disp_d = BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= LD_A;
         op_a_q       <= '0;
         shift_data_q <= '0;
         shift_num_q  <= '0;
         shift_op_q   <= '0;
         alu_op_q     <= '0;
         cf_q         <= 1'b0;
         vf_q         <= 1'b0;
         disp_q       <= BLANK;
         res_nzcv_q   <= '0;
         res_cout_q   <= 1'b0;
         res_f_q      <= '0;
         res_s_q      <= '0;
         step_q       <= 2'd0;
         busy_q       <= 1'b0;
         settle_q     <= '0;
         view_q       <= 2'd0;
      end else begin
         case (state_q)
            LD_A: begin
               if (load_ev) begin
                  op_a_q  <= bus.sw;
                  disp_q  <= {bus.sw, 1'b1};
                  step_q  <= 2'd1;
                  state_q <= LD_SD;
               end
            end
            LD_SD: begin
               if (load_ev) begin
                  shift_data_q <= bus.sw;
                  disp_q       <= {bus.sw, 1'b1};
                  step_q       <= 2'd2;
                  state_q      <= LD_CTL;
               end
            end
            LD_CTL: begin
               if (load_ev) begin
                  {shift_num_q, shift_op_q, alu_op_q, cf_q, vf_q} <= bus.sw[31:15];
                  disp_q   <= {bus.sw[31:15], 15'h0, 1'b1};
                  step_q   <= 2'd0;
                  settle_q <= SETTLE_INI;
                  busy_q   <= 1'b1;
                  state_q  <= SETTLE;
               end
            end
            SETTLE: begin
               // Datapath inputs have been stable since commit; buttons are ignored here.
               if (settle_q == 4'd0) begin
                  res_nzcv_q <= bus.alu_nzcv;
                  res_cout_q <= bus.shift_cout;
                  res_f_q    <= bus.alu_f;
                  res_s_q    <= bus.shift_out;
                  view_q     <= 2'd0;
                  disp_q     <= {bus.alu_f, 1'b1};
                  busy_q     <= 1'b0;
                  state_q    <= DONE;
`ifdef FLAG_WRITEBACK_EN
                  cf_q       <= bus.alu_nzcv[1];
                  vf_q       <= bus.alu_nzcv[0];
`endif
               end else begin
                  settle_q <= settle_q - 4'd1;
               end
            end
            DONE: begin
               // A load press takes priority over a coincident show press.
               if (load_ev) begin
                  op_a_q  <= bus.sw;
                  disp_q  <= {bus.sw, 1'b1};
                  step_q  <= 2'd1;
                  state_q <= LD_SD;
               end else if (press_show) begin
                  view_q <= view_d;
                  disp_q <= view_disp_d;
               end
            end
            default: begin
               state_q <= LD_A;
            end
         endcase
      end
   end

   assign bus.op_a       = op_a_q;
   assign bus.shift_data = shift_data_q;
   assign bus.shift_num  = shift_num_q;
   assign bus.shift_op   = shift_op_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.cf         = cf_q;
   assign bus.vf         = vf_q;
   assign bus.disp_data  = disp_q;
   assign bus.res_nzcv   = res_nzcv_q;
   assign bus.res_cout   = res_cout_q;
   assign bus.step       = step_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed steps plus random operand sequences against a behavioural model.
module tb_alu_op_sequencer;
   localparam int D = 6;
   localparam int S = 3;
   localparam logic [32:0] BLANK = {32'h8888_8888, 1'b0};

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   alu_op_sequencer_if bus ();

   alu_op_sequencer #(.DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Datapath stand-in: adder with carry-in, left shifter.
   function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic cin);
      logic [32:0] s;
      logic [31:0] f;
      logic        v;
      s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      f = s[31:0];
      v = (a[31] == b[31]) && (f[31] != a[31]);
      return {f[31], (f == 32'd0), s[32], v, f};
   endfunction

   assign {bus.alu_nzcv, bus.alu_f} = alu_ref(bus.op_a, bus.shift_data, bus.cf);
   assign bus.shift_out  = bus.shift_data << bus.shift_num[4:0];
   assign bus.shift_cout = bus.shift_data[31] ^ bus.cf;

   // Reference model state
   logic [31:0] exp_op_a, exp_sd, res_f, res_s;
   logic [7:0]  exp_shift_num;
   logic [2:0]  exp_shift_op;
   logic [3:0]  exp_alu_op, exp_res_nzcv;
   logic        exp_cf, exp_vf, exp_res_cout, exp_busy;
   logic [32:0] exp_disp;
   logic [1:0]  exp_step;
   int          m_phase, m_view;
   bit          m_armed;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".op_a"},       33'(bus.op_a),       33'(exp_op_a));
      chk({tag, ".shift_data"}, 33'(bus.shift_data), 33'(exp_sd));
      chk({tag, ".shift_num"},  33'(bus.shift_num),  33'(exp_shift_num));
      chk({tag, ".shift_op"},   33'(bus.shift_op),   33'(exp_shift_op));
      chk({tag, ".alu_op"},     33'(bus.alu_op),     33'(exp_alu_op));
      chk({tag, ".cf"},         33'(bus.cf),         33'(exp_cf));
      chk({tag, ".vf"},         33'(bus.vf),         33'(exp_vf));
      chk({tag, ".disp"},       bus.disp_data,       exp_disp);
      chk({tag, ".res_nzcv"},   33'(bus.res_nzcv),   33'(exp_res_nzcv));
      chk({tag, ".res_cout"},   33'(bus.res_cout),   33'(exp_res_cout));
      chk({tag, ".step"},       33'(bus.step),       33'(exp_step));
      chk({tag, ".busy"},       33'(bus.busy),       33'(exp_busy));
   endtask

   task automatic m_reset();
      exp_op_a = '0; exp_sd = '0; exp_shift_num = '0; exp_shift_op = '0; exp_alu_op = '0;
      exp_cf = 1'b0; exp_vf = 1'b0; exp_res_nzcv = '0; exp_res_cout = 1'b0;
      res_f = '0; res_s = '0; exp_busy = 1'b0; exp_step = 2'd0; exp_disp = BLANK;
      m_phase = 0; m_view = 0; m_armed = 1'b0;
   endtask

   task automatic m_load(input logic [31:0] v);
      case (m_phase)
         0, 3: begin exp_op_a = v; exp_disp = {v, 1'b1}; exp_step = 2'd1; m_phase = 1; end
         1:    begin exp_sd = v;   exp_disp = {v, 1'b1}; exp_step = 2'd2; m_phase = 2; end
         default: begin
            exp_shift_num = v[31:24]; exp_shift_op = v[23:21]; exp_alu_op = v[20:17];
            exp_cf = v[16]; exp_vf = v[15];
            exp_disp = {v[31:15], 15'h0, 1'b1}; exp_step = 2'd0; exp_busy = 1'b1; m_phase = 4;
         end
      endcase
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input int idx, input logic v);
      case (idx)
         0:       bus.btn_load = v;
         1:       bus.btn_arm  = v;
         default: bus.btn_show = v;
      endcase
   endtask

   task automatic do_load(input logic [31:0] v);
      logic [35:0] r;
      bus.sw = v;
      set_btn(0, 1'b1);
      tick(D + 3);
      if (m_armed) m_load(v);
      check_all("load");
      if (m_phase == 4) begin
         repeat (S) begin
            tick(1);
            check_all("settle");
         end
         tick(1);
         r = alu_ref(exp_op_a, exp_sd, exp_cf);
         exp_res_nzcv = r[35:32];
         exp_res_cout = exp_sd[31] ^ exp_cf;
         res_f = r[31:0];
         res_s = exp_sd << exp_shift_num[4:0];
         exp_disp = {res_f, 1'b1};
         exp_busy = 1'b0;
         m_view = 0;
         m_phase = 3;
`ifdef FLAG_WRITEBACK_EN
         exp_cf = r[33];
         exp_vf = r[32];
`endif
         check_all("capture");
      end
      set_btn(0, 1'b0);
      tick(D + 4);
   endtask

   task automatic do_show();
      set_btn(2, 1'b1);
      tick(D + 3);
      if (m_phase == 3) begin
         m_view = (m_view + 1) % 3;
         exp_disp = (m_view == 0) ? {res_f, 1'b1} : (m_view == 1) ? {res_s, 1'b1} : BLANK;
      end
      check_all("show");
      set_btn(2, 1'b0);
      tick(D + 4);
   endtask

   task automatic set_arm(input logic v);
      set_btn(1, v);
      tick(D + 4);
      m_armed = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.sw = '0; bus.btn_load = 1'b0; bus.btn_arm = 1'b0; bus.btn_show = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      m_reset();
      check_all("reset");
      tick(2);
      rst_n = 1'b1;
      tick(2);
      set_arm(1'b1);

      // Glitch shorter than the debounce window
      bus.sw = 32'h0000_00FF;
      set_btn(0, 1'b1);
      tick(D - 2);
      set_btn(0, 1'b0);
      tick(D + 4);
      check_all("short_pulse");

      // Exact press-to-output latency
      set_btn(0, 1'b1);
      tick(D + 2);
      chk("lat_before.step", 33'(bus.step), 33'd0);
      tick(1);
      m_load(32'h0000_00FF);
      check_all("lat_after");
      chk("lat_after.op_a_ff", 33'(bus.op_a), 33'h0_0000_00FF);
      set_btn(0, 1'b0);
      tick(D + 4);

      do_show();

      // Reset in the middle of LD_SD
      rst_n = 1'b0;
      #1;
      m_reset();
      check_all("rst_mid");
      chk("rst_mid.disp_const", bus.disp_data, 33'h1_1111_1110);
      tick(2);
      rst_n = 1'b1;
      set_arm(1'b1);

      set_arm(1'b0);
      do_load(32'h1234_5678);
      chk("unarmed.step", 33'(bus.step), 33'd0);
      set_arm(1'b1);

      do_load(32'h7FFF_FFFF);
      do_load(32'h0000_0001);
      do_load(32'h0000_0000);
      chk("seq.res_nzcv", 33'(bus.res_nzcv), 33'h9);
      chk("seq.disp", bus.disp_data, {32'h8000_0000, 1'b1});

      do_show();
      chk("show1.const", bus.disp_data, {32'h0000_0001, 1'b1});
      do_show();
      chk("show2.const", bus.disp_data, BLANK);
      do_show();
      chk("show3.const", bus.disp_data, {32'h8000_0000, 1'b1});
      do_show();

      // Load and show land in the same cycle: load wins
      bus.sw = 32'hCAFE_0001;
      set_btn(0, 1'b1);
      set_btn(2, 1'b1);
      tick(D + 3);
      m_load(32'hCAFE_0001);
      check_all("simul");
      chk("simul.op_a", 33'(bus.op_a), 33'h0_CAFE_0001);
      set_btn(0, 1'b0);
      set_btn(2, 1'b0);
      tick(D + 4);
      do_load(32'h0000_0010);
      do_load(32'h0000_0000);

      do_load(32'h8000_0000);
      do_load(32'h8000_0001);
      do_load(32'h0000_0000);
      chk("wb.res_nzcv", 33'(bus.res_nzcv), 33'h3);
`ifdef FLAG_WRITEBACK_EN
      chk("wb.cf", 33'(bus.cf), 33'd1);
      chk("wb.vf", 33'(bus.vf), 33'd1);
`else
      chk("wb.cf", 33'(bus.cf), 33'd0);
      chk("wb.vf", 33'(bus.vf), 33'd0);
`endif

      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               set_arm(1'b0);
               do_load($urandom);
               set_arm(1'b1);
            end
            do_load($urandom);
         end
         for (int s = $urandom_range(0, 3); s > 0; s--) do_show();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
